nibble_add_seq: RTL and testbench

Multi-cycle sequencer that performs wide add/subtract by time-multiplexing one external 4-bit ripple adder slice with carry-in, one nibble per clock, LSB first. It latches operands on a start handshake, drives the slice, registers each sum nibble and the carry chain, and reports sum, carry-out and signed overflow with a one-cycle done pulse. It sits between a requesting controller and the shared 4-bit adder datapath.

---
 rtl/nibble_add_seq_if.sv | 18 +
 rtl/nibble_add_seq.sv | 92 +++++++++
 tb/tb_nibble_add_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/nibble_add_seq_if.sv
// Request/response bus of the nibble sequencer plus the port to the shared 4-bit adder slice.
interface nibble_add_seq_if #(parameter int NIBBLES = 4);
  localparam int W = 4*NIBBLES;

  logic         start, sub, cin;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout, ovf;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_ci, add_co;

  // master is the requesting controller together with the adder slice it owns
  modport master (output start, sub, cin, a, b, add_s, add_co,
                  input  busy, done, sum, cout, ovf, add_a, add_b, add_ci);
  modport slave  (input  start, sub, cin, a, b, add_s, add_co,
                  output busy, done, sum, cout, ovf, add_a, add_b, add_ci);
endinterface

// File: rtl/nibble_add_seq.sv
// Wide add/subtract sequencer: time-multiplexes one external 4-bit adder slice,
// one nibble per clock LSB first, and reports sum/carry/overflow with a done pulse.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  nibble_add_seq_if.slave   bus
);
  localparam int W  = 4*NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES-1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic          carry_q, sa_q, sb_q, cout_q, ovf_q;
  logic          accept, last;

  assign last = (idx == LAST);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        // a start seen during the done cycle chains straight into the next op
        accept    = bus.start;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // subtraction is A + ~B + 1, so B is inverted once at latch time
        a_q     <= bus.a;
        b_q     <= bus.sub ? ~bus.b : bus.b;
        carry_q <= bus.sub ? 1'b1 : bus.cin;
        sa_q    <= bus.a[W-1];
        sb_q    <= bus.sub ? ~bus.b[W-1] : bus.b[W-1];
        idx     <= '0;
      end else if (state == RUN) begin
        sum_q[4*idx +: 4] <= bus.add_s;
        carry_q           <= bus.add_co;
        idx               <= last ? '0 : idx + IW'(1);
        if (last) begin
          cout_q <= bus.add_co;
          ovf_q  <= (sa_q == sb_q) && (bus.add_s[3] != sa_q);
        end
      end
    end
  end

  always_comb begin
    bus.add_a  = 4'h0;
    bus.add_b  = 4'h0;
    bus.add_ci = 1'b0;
    if (state == RUN) begin
      bus.add_a  = a_q[4*idx +: 4];
      bus.add_b  = b_q[4*idx +: 4];
      bus.add_ci = carry_q;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq: arithmetic/timeline model checked every cycle plus literal checks.
module tb_nibble_add_seq;
  localparam int N = 4;
  localparam int W = 4*N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_add_seq_if #(.NIBBLES(N)) bus();
  nibble_add_seq #(.NIBBLES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // shared adder slice
  assign {bus.add_co, bus.add_s} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_ci);

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1..N run (nibble phase-1), N+1 done
  int           phase = 0;
  bit           armed = 0;
  logic [W-1:0] m_a, m_b, p_sum, h_sum;
  logic         m_c0, p_cout, p_ovf, h_cout, h_ovf;

  always @(posedge clk) begin
    logic [W:0] r;
    if (!rst_n) begin
      armed = 1; phase = 0; h_sum = '0; h_cout = 0; h_ovf = 0;
    end else if ((phase == 0 || phase == N+1) && bus.start) begin
      m_a    = bus.a;
      m_b    = bus.sub ? ~bus.b : bus.b;
      m_c0   = bus.sub ? 1'b1 : bus.cin;
      r      = {1'b0, m_a} + {1'b0, m_b} + (W+1)'(m_c0);
      p_sum  = r[W-1:0];
      p_cout = r[W];
      p_ovf  = (m_a[W-1] == m_b[W-1]) && (r[W-1] != m_a[W-1]);
      phase  = 1;
    end else if (phase >= 1 && phase < N) begin
      phase++;
    end else if (phase == N) begin
      phase = N+1; h_sum = p_sum; h_cout = p_cout; h_ovf = p_ovf;
    end else begin
      phase = 0;
    end
  end

  always @(negedge clk) begin
    int k;
    logic [W-1:0] mask;
    logic [W:0]   t;
    if (armed) begin
      chk("busy", bus.busy, 32'(phase >= 1 && phase <= N));
      chk("done", bus.done, 32'(phase == N+1));
      if (phase >= 1 && phase <= N) begin
        k    = phase - 1;
        mask = (W'(1) << (4*k)) - W'(1);
        t    = {1'b0, m_a & mask} + {1'b0, m_b & mask} + (W+1)'(m_c0);
        chk("add_a",  bus.add_a,  32'((m_a >> (4*k)) & W'(15)));
        chk("add_b",  bus.add_b,  32'((m_b >> (4*k)) & W'(15)));
        chk("add_ci", bus.add_ci, 32'(t[4*k]));
      end else begin
        chk("add_a_idle",  bus.add_a,  0);
        chk("add_b_idle",  bus.add_b,  0);
        chk("add_ci_idle", bus.add_ci, 0);
        chk("sum",  bus.sum,  h_sum);
        chk("cout", bus.cout, h_cout);
        chk("ovf",  bus.ovf,  h_ovf);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input logic [W-1:0] es, input logic ec,
                           input logic eo, input int lat);
    int n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_lat"},  n, lat);
    chk({nm, "_sum"},  bus.sum, es);
    chk({nm, "_cout"}, bus.cout, ec);
    chk({nm, "_ovf"},  bus.ovf, eo);
  endtask

  initial begin
    logic [3:0] nib_a [4];
    nib_a = '{4'h3, 4'hC, 4'h5, 4'hA};
    bus.start = 0; bus.sub = 0; bus.cin = 0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", bus.sum, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(16'h1234, 16'h4321, 0, 0); wait_done("add1", 16'h5555, 0, 0, N);
    @(posedge clk); #1;
    issue(16'hFFFF, 16'h0001, 0, 0); wait_done("add2", 16'h0000, 1, 0, N);
    @(posedge clk); #1;
    issue(16'h7FFF, 16'h0001, 0, 0); wait_done("add3", 16'h8000, 0, 1, N);
    @(posedge clk); #1;
    issue(16'h0005, 16'h0007, 1, 1); wait_done("sub1", 16'hFFFE, 0, 0, N);
    @(posedge clk); #1;
    issue(16'h8000, 16'h0001, 1, 0); wait_done("sub2", 16'h7FFF, 1, 1, N);

    // back-to-back: new start issued in the done cycle
    @(posedge clk); #1;
    issue(16'h1111, 16'h2222, 0, 0); wait_done("b2b1", 16'h3333, 0, 0, N);
    issue(16'h0001, 16'h0001, 0, 0); wait_done("b2b2", 16'h0002, 0, 0, N);

    // start pulse mid-RUN with other operands is ignored
    @(posedge clk); #1;
    issue(16'h1000, 16'h0234, 0, 0);
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1; bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    wait_done("ignore", 16'h1234, 0, 0, N-1);
    repeat (3) @(posedge clk);
    #1;

    // reset during nibble 2
    issue(16'h1111, 16'h1111, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstmid_sum", bus.sum, 0);
    chk("rstmid_busy", bus.busy, 0);
    repeat (6) @(posedge clk);
    #1;
    issue(16'h00FF, 16'h0001, 0, 0); wait_done("postrst", 16'h0100, 0, 0, N);

    // per-nibble slice drive, carry ripples through every nibble
    @(posedge clk); #1;
    issue(16'hA5C3, 16'h5A3D, 0, 1);
    for (int k = 0; k < N; k++) begin
      chk("slice_a",  bus.add_a, nib_a[k]);
      chk("slice_ci", bus.add_ci, 1);
      @(posedge clk); #1;
    end
    wait_done("slice", 16'h0001, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
